// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU op codes and FSM state encoding for digit_serial_alu.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 2'd0;
    localparam alu_op_t ALU_SUB = 2'd1;
    localparam alu_op_t ALU_AND = 2'd2;
    localparam alu_op_t ALU_XOR = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_run  = 2'd1;
    localparam state_t c_st_done = 2'd2;

endpackage
`default_nettype wire

// File: rtl/digit_adder_slice.sv
`default_nettype none
// ============================================================================
// Module      : digit_adder_slice
// Description : Combinational DIGIT-bit ripple slice; add or bitwise AND/XOR.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_adder_slice
    import alu_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [DIGIT-1:0] sum_d,
    output logic             cout_d
);

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_sum;

    assign w_c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign w_sum[i]   = a_d[i] ^ b_d[i] ^ w_c[i];
        assign w_c[i + 1] = (a_d[i] & b_d[i]) | (w_c[i] & (a_d[i] ^ b_d[i]));
    end

    // SUB arrives with a_d already inverted and cin seeded, so it shares the add path
    always_comb begin
        sum_d  = w_sum;
        cout_d = w_c[DIGIT];
        case (op)
            ALU_AND: begin
                sum_d  = a_d & b_d;
                cout_d = 1'b0;
            end
            ALU_XOR: begin
                sum_d  = a_d ^ b_d;
                cout_d = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/digit_serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_alu
// Description : Multi-cycle Y86 ALU, DIGIT bits per cycle LSB first, with flags.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] c_last_digit = CNT_W'(NUM_DIGITS - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("digit_serial_alu: WIDTH must be a multiple of DIGIT");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic              r_zf_acc;
    logic              r_a_msb;
    logic              r_b_msb;
    logic [CNT_W-1:0]  r_cnt;
    logic [DIGIT-1:0]  w_sum_d;
    logic              w_cout_d;
    logic [WIDTH-1:0]  w_acc_next;
    logic              w_accept;
    logic              w_run;
    logic              w_last;
    logic              w_of;

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign w_accept  = in_valid && in_ready;
    assign w_run     = (r_state == c_st_run);
    assign w_last    = w_run && (r_cnt == c_last_digit);

    digit_adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a_d    (r_a[DIGIT-1:0]),
        .b_d    (r_b[DIGIT-1:0]),
        .cin    (r_carry),
        .op     (r_op),
        .sum_d  (w_sum_d),
        .cout_d (w_cout_d)
    );

    // Result digits enter from the MSB side; the final digit completes the word
    if (NUM_DIGITS == 1) begin : g_single
        assign w_acc_next = w_sum_d;
    end else begin : g_multi
        logic [WIDTH-DIGIT-1:0] r_acc;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (w_run) begin
                r_acc <= w_acc_next[WIDTH-1:DIGIT];
            end
        end
        assign w_acc_next = {w_sum_d, r_acc};
    end

    always_comb begin
        w_of = 1'b0;
        case (r_op)
            ALU_ADD: w_of = (r_a_msb == r_b_msb) && (w_sum_d[DIGIT-1] != r_a_msb);
            ALU_SUB: w_of = (r_a_msb != r_b_msb) && (w_sum_d[DIGIT-1] != r_b_msb);
            default: w_of = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (in_valid)  w_state_next = c_st_run;
            c_st_run:  if (w_last)    w_state_next = c_st_done;
            c_st_done: if (out_ready) w_state_next = c_st_idle;
            default:                  w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= ALU_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_zf_acc <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
            y        <= '0;
            cout     <= 1'b0;
            zf       <= 1'b0;
            sf       <= 1'b0;
            of       <= 1'b0;
        end else if (w_accept) begin
            r_op     <= op;
            r_a      <= (op == ALU_SUB) ? ~a : a;
            r_b      <= b;
            r_carry  <= (op == ALU_SUB);
            r_zf_acc <= 1'b1;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_cnt    <= '0;
        end else if (w_run) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_carry  <= w_cout_d;
            r_zf_acc <= r_zf_acc & (w_sum_d == '0);
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                y    <= w_acc_next;
                cout <= w_cout_d;
                zf   <= r_zf_acc & (w_sum_d == '0);
                sf   <= w_sum_d[DIGIT-1];
                of   <= w_of;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_serial_alu
// Description : Directed and randomised checks of digit_serial_alu at DIGIT=8,1,16,64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_alu;
    import alu_pkg::*;

    localparam int N = 4;
    localparam int DG_TAB [N] = '{8, 1, 16, 64};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_v  [N];
    logic        in_ready_v  [N];
    logic        out_valid_v [N];
    logic        out_ready_v [N];
    logic        cout_v      [N];
    logic        zf_v        [N];
    logic        sf_v        [N];
    logic        of_v        [N];
    logic [1:0]  op_v        [N];
    logic [63:0] a_v         [N];
    logic [63:0] b_v         [N];
    logic [63:0] y_v         [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        digit_serial_alu #(.WIDTH(64), .DIGIT(DG_TAB[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .op        (op_v[g]),
            .a         (a_v[g]),
            .b         (b_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .y         (y_v[g]),
            .cout      (cout_v[g]),
            .zf        (zf_v[g]),
            .sf        (sf_v[g]),
            .of        (of_v[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input int k, input string tag, input logic [63:0] ey,
                           input logic ec, input logic ez, input logic es, input logic eo);
        chk({tag, "_y"},    y_v[k],       ey);
        chk({tag, "_cout"}, cout_v[k],    ec);
        chk({tag, "_zf"},   zf_v[k],      ez);
        chk({tag, "_sf"},   sf_v[k],      es);
        chk({tag, "_of"},   of_v[k],      eo);
        chk({tag, "_ov"},   out_valid_v[k], 1'b1);
    endtask

    // Returns after out_valid rises; lat counts edges after the accept edge
    task automatic do_op(input int k, input logic [1:0] o, input logic [63:0] aa,
                         input logic [63:0] bb, output int lat);
        @(negedge clk);
        chk("in_ready_idle", in_ready_v[k], 1'b1);
        op_v[k] = o;
        a_v[k] = aa;
        b_v[k] = bb;
        in_valid_v[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[k] = 1'b0;
        lat = 0;
        while (out_valid_v[k] !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input int k);
        out_ready_v[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[k] = 1'b0;
        chk("consume_ov", out_valid_v[k], 1'b0);
        chk("consume_ir", in_ready_v[k], 1'b1);
    endtask

    task automatic model(input logic [1:0] o, input logic [63:0] aa, input logic [63:0] bb,
                         output logic [63:0] ey, output logic ec, output logic ez,
                         output logic es, output logic eo);
        logic [64:0] s;
        s  = '0;
        eo = 1'b0;
        case (o)
            ALU_ADD: begin
                s  = {1'b0, bb} + {1'b0, aa};
                eo = (aa[63] == bb[63]) && (s[63] != aa[63]);
            end
            ALU_SUB: begin
                s  = {1'b0, bb} + {1'b0, ~aa} + 65'd1;
                eo = (aa[63] != bb[63]) && (s[63] != bb[63]);
            end
            ALU_AND: s = {1'b0, bb & aa};
            default: s = {1'b0, bb ^ aa};
        endcase
        ey = s[63:0];
        ec = s[64];
        ez = (ey == 64'd0);
        es = ey[63];
    endtask

    initial begin
        int          lat;
        logic [1:0]  ro;
        logic [63:0] ra, rb, ey;
        logic        ec, ez, es, eo;

        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid_v[i]  = 1'b0;
            out_ready_v[i] = 1'b0;
            op_v[i]        = ALU_ADD;
            a_v[i]         = '0;
            b_v[i]         = '0;
        end
        #12;
        chk("rst_y",  y_v[0], 64'd0);
        chk("rst_ov", out_valid_v[0], 1'b0);
        chk("rst_ir", in_ready_v[0], 1'b1);
        chk("rst_flags", {cout_v[0], zf_v[0], sf_v[0], of_v[0]}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, ALU_ADD, 64'd5, 64'd3, lat);
        chk("add_lat", lat, 8);
        chk_res(0, "add_5_3", 64'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        consume(0);

        do_op(0, ALU_SUB, 64'd5, 64'd5, lat);
        chk_res(0, "sub_eq", 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        consume(0);

        do_op(0, ALU_SUB, 64'd1, 64'h8000_0000_0000_0000, lat);
        chk_res(0, "sub_of", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        consume(0);

        do_op(0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, lat);
        chk_res(0, "add_pos_of", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);
        consume(0);

        do_op(0, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        chk_res(0, "add_ones", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
        consume(0);

        do_op(0, ALU_AND, 64'hF0F0, 64'hFF00, lat);
        chk_res(0, "and", 64'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
        consume(0);

        do_op(0, ALU_XOR, 64'h1234, 64'h1234, lat);
        chk_res(0, "xor_zero", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        consume(0);

        // Backpressure: result must hold while new operands are offered
        do_op(0, ALU_ADD, 64'h10, 64'h20, lat);
        for (int i = 0; i < 5; i++) begin
            op_v[0] = ALU_XOR;
            a_v[0] = {$urandom, $urandom};
            b_v[0] = 64'hDEAD;
            in_valid_v[0] = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_ov", out_valid_v[0], 1'b1);
            chk("hold_ir", in_ready_v[0], 1'b0);
            chk_res(0, "hold", 64'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        in_valid_v[0] = 1'b0;
        consume(0);
        do_op(0, ALU_SUB, 64'd3, 64'd10, lat);
        chk("after_hold_lat", lat, 8);
        chk_res(0, "after_hold", 64'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        consume(0);

        // Abort during digit 3 of a run
        @(negedge clk);
        op_v[0] = ALU_ADD;
        a_v[0] = 64'h1111;
        b_v[0] = 64'h2222;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_y", y_v[0], 64'd0);
        chk("abort_flags", {cout_v[0], zf_v[0], sf_v[0], of_v[0]}, 4'b0000);
        chk("abort_ov", out_valid_v[0], 1'b0);
        chk("abort_ir", in_ready_v[0], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_pulse", out_valid_v[0], 1'b0);
        end

        // Other digit widths against the flat model
        for (int k = 1; k < N; k++) begin
            for (int i = 0; i < 6; i++) begin
                ro = 2'(i % 4);
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (i == 0) begin
                    ra = 64'hFFFF_FFFF_FFFF_FFFF;
                    rb = 64'd1;
                end
                if (i == 1) rb = ra;
                model(ro, ra, rb, ey, ec, ez, es, eo);
                do_op(k, ro, ra, rb, lat);
                chk($sformatf("lat_d%0d", DG_TAB[k]), lat, 64 / DG_TAB[k]);
                chk_res(k, $sformatf("rand_d%0d_op%0d", DG_TAB[k], ro), ey, ec, ez, es, eo);
                consume(k);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
